// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of an asynchronous pulse in clk cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   pulse_in  in   pulse to measure, asynchronous to clk
//   arm       in   single-cycle request to start a measurement (honoured only in IDLE)
//   abort     in   cancels any measurement in progress, returns to IDLE
//   width     out  last captured high time in cycles (saturates at all-ones)
//   valid     out  one-cycle strobe marking the capture of width/overflow
//   overflow  out  the captured pulse saturated the counter
//   busy      out  high whenever the measurement FSM is not IDLE
//
// Parameters:
//   WIDTH       counter / width output size in bits
//   MIN_WIDTH   pulses shorter than this many cycles are dropped as glitches (1 = no rejection)
//   CONTINUOUS  0: back to IDLE after each capture, 1: re-arm automatically

module pulse_width_meter #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned MIN_WIDTH  = 2,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             arm,
    input  logic             abort,
    output logic [WIDTH-1:0] width,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] MIN_CNT   = WIDTH'(MIN_WIDTH);
    localparam logic             AUTO_REARM = (CONTINUOUS != 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_MEASURE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] width_q, width_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             s;

    // Two-flop synchronizer; every FSM decision looks only at the second stage.
    assign sync_d = {sync_q[0], pulse_in};
    assign s      = sync_q[1];

    // Next-state and capture logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        width_d    = width_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        if (abort) begin
            // Abort wins over arm and over a capture in the same cycle.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    // Skip a pulse that was already high when arm arrived.
                    if (!s) begin
                        state_d = ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    if (s) begin
                        count_d = WIDTH'(1);
                        ovf_d   = 1'b0;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (s) begin
                        if (count_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else if (count_q < MIN_CNT) begin
                        state_d = ST_WAIT_RISE;
                    end else begin
                        width_d    = count_q;
                        overflow_d = ovf_q;
                        valid_d    = 1'b1;
                        state_d    = AUTO_REARM ? ST_WAIT_RISE : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // busy is registered from the next state so it mirrors the state register exactly.
    assign busy_d = (state_d != ST_IDLE);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b00;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            width_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            width_q    <= width_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign width    = width_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: four parameterisations of pulse_width_meter driven by a shared
// stimulus, each compared every cycle against a run-length reference model, plus
// directed checks of the documented scenarios.

module tb_pulse_width_meter;

    localparam int NI = 4;
    localparam int PW   [NI] = '{8, 4, 8, 5};
    localparam int PMIN [NI] = '{2, 2, 2, 1};
    localparam int PCONT[NI] = '{0, 0, 1, 1};

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       arm;
    logic       abort;
    logic [7:0] width0;
    logic [3:0] width1;
    logic [7:0] width2;
    logic [4:0] width3;
    logic [3:0] valid_v;
    logic [3:0] ovf_v;
    logic [3:0] busy_v;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int nv[NI];
    int t_valid0 = 0;
    int t_fall   = 0;

    // Reference model state: synchronizer delay line plus a run-length view per instance.
    bit m_s1, m_s2;
    bit m_armed[NI];
    bit m_need_low[NI];
    bit m_in_pulse[NI];
    int m_run[NI];
    bit m_valid[NI];
    bit m_ovf[NI];
    int m_width[NI];

    pulse_width_meter #(.WIDTH(8), .MIN_WIDTH(2), .CONTINUOUS(0)) u_dut0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .arm(arm), .abort(abort),
        .width(width0), .valid(valid_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0]));
    pulse_width_meter #(.WIDTH(4), .MIN_WIDTH(2), .CONTINUOUS(0)) u_dut1 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .arm(arm), .abort(abort),
        .width(width1), .valid(valid_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1]));
    pulse_width_meter #(.WIDTH(8), .MIN_WIDTH(2), .CONTINUOUS(1)) u_dut2 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .arm(arm), .abort(abort),
        .width(width2), .valid(valid_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2]));
    pulse_width_meter #(.WIDTH(5), .MIN_WIDTH(1), .CONTINUOUS(1)) u_dut3 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .arm(arm), .abort(abort),
        .width(width3), .valid(valid_v[3]), .overflow(ovf_v[3]), .busy(busy_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int obs_width(input int i);
        case (i)
            0:       return int'(width0);
            1:       return int'(width1);
            2:       return int'(width2);
            default: return int'(width3);
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit s;
        int maxv;
        s = m_s2;
        if (rst) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = pulse_in;
        end
        for (int i = 0; i < NI; i++) begin
            maxv = (1 << PW[i]) - 1;
            m_valid[i] = 1'b0;
            if (rst) begin
                m_armed[i] = 1'b0; m_need_low[i] = 1'b0; m_in_pulse[i] = 1'b0;
                m_run[i] = 0; m_ovf[i] = 1'b0; m_width[i] = 0;
            end else if (abort) begin
                m_armed[i] = 1'b0;
            end else if (!m_armed[i]) begin
                if (arm) begin
                    m_armed[i] = 1'b1; m_need_low[i] = 1'b1; m_in_pulse[i] = 1'b0;
                end
            end else if (m_need_low[i]) begin
                if (!s) m_need_low[i] = 1'b0;
            end else if (!m_in_pulse[i]) begin
                if (s) begin
                    m_in_pulse[i] = 1'b1;
                    m_run[i] = 1;
                end
            end else if (s) begin
                m_run[i]++;
            end else begin
                m_in_pulse[i] = 1'b0;
                if (m_run[i] >= PMIN[i]) begin
                    m_valid[i] = 1'b1;
                    m_width[i] = (m_run[i] > maxv) ? maxv : m_run[i];
                    m_ovf[i]   = (m_run[i] > maxv);
                    if (PCONT[i] == 0) m_armed[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            expect_eq($sformatf("valid[%0d]", i), int'(valid_v[i]), int'(m_valid[i]));
            expect_eq($sformatf("busy[%0d]", i), int'(busy_v[i]), int'(m_armed[i]));
            expect_eq($sformatf("width[%0d]", i), obs_width(i), m_width[i]);
            expect_eq($sformatf("overflow[%0d]", i), int'(ovf_v[i]), int'(m_ovf[i]));
            if (valid_v[i]) nv[i]++;
        end
        if (valid_v[0]) t_valid0 = cyc;
    endtask

    task automatic run_level(input bit lvl, input int n);
        pulse_in = lvl;
        repeat (n) step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic step_rand(input bit try_arm);
        arm   = try_arm;
        abort = ($urandom_range(0, 24) == 0);
        rst   = ($urandom_range(0, 299) == 0);
        step();
        arm   = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int nv_mark;
        int lo;
        int hi;
        bit do_arm;

        for (int i = 0; i < NI; i++) nv[i] = 0;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; pulse_in = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        expect_eq("rst_busy0", int'(busy_v[0]), 0);
        expect_eq("rst_width0", int'(width0), 0);

        // Basic capture: 5 low edges (arm edge included), 37 high, then low.
        pulse_arm();
        run_level(1'b0, 4);
        run_level(1'b1, 37);
        t_fall = cyc + 1;
        run_level(1'b0, 6);
        expect_eq("basic_nvalid0", nv[0], 1);
        expect_eq("basic_width0", int'(width0), 37);
        expect_eq("basic_ovf0", int'(ovf_v[0]), 0);
        expect_eq("basic_busy0", int'(busy_v[0]), 0);
        expect_eq("basic_latency0", t_valid0, t_fall + 2);
        expect_eq("ovf_width1", int'(width1), 15);
        expect_eq("ovf_flag1", int'(ovf_v[1]), 1);
        expect_eq("ovf_nvalid1", nv[1], 1);

        // Pulse already high at arm is skipped; the following 20-edge pulse is measured.
        run_level(1'b1, 3);
        pulse_arm();
        run_level(1'b1, 6);
        run_level(1'b0, 4);
        run_level(1'b1, 20);
        run_level(1'b0, 6);
        expect_eq("prehigh_nvalid0", nv[0], 2);
        expect_eq("prehigh_width0", int'(width0), 20);

        // Glitch rejection: 1-edge glitch dropped, 6-edge pulse captured.
        pulse_arm();
        run_level(1'b0, 3);
        run_level(1'b1, 1);
        run_level(1'b0, 3);
        expect_eq("glitch_busy0", int'(busy_v[0]), 1);
        expect_eq("glitch_nvalid0", nv[0], 2);
        run_level(1'b1, 6);
        run_level(1'b0, 6);
        expect_eq("glitch_width0", int'(width0), 6);
        expect_eq("glitch_nvalid0b", nv[0], 3);

        // Re-armed short pulse after overflow clears the overflow flag.
        pulse_arm();
        run_level(1'b0, 3);
        run_level(1'b1, 3);
        run_level(1'b0, 6);
        expect_eq("rearm_width1", int'(width1), 3);
        expect_eq("rearm_ovf1", int'(ovf_v[1]), 0);

        // Continuous mode: three pulses give three strobes.
        nv_mark = nv[2];
        pulse_arm();
        run_level(1'b0, 3);
        run_level(1'b1, 4);
        run_level(1'b0, 4);
        run_level(1'b1, 9);
        run_level(1'b0, 4);
        run_level(1'b1, 2);
        run_level(1'b0, 4);
        expect_eq("cont_nvalid2", nv[2] - nv_mark, 3);
        expect_eq("cont_width2", int'(width2), 2);
        expect_eq("cont_busy2", int'(busy_v[2]), 1);
        expect_eq("single_width0", int'(width0), 4);

        // Abort at count 12, with an ignored arm during MEASURE beforehand.
        nv_mark = nv[0];
        pulse_arm();
        run_level(1'b0, 3);
        run_level(1'b1, 7);
        pulse_arm();
        run_level(1'b1, 6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_eq("abort_busy0", int'(busy_v[0]), 0);
        expect_eq("abort_width0", int'(width0), 4);
        run_level(1'b1, 2);
        run_level(1'b0, 6);
        expect_eq("abort_nvalid0", nv[0] - nv_mark, 0);

        // Reset in the middle of a measurement.
        pulse_arm();
        run_level(1'b0, 3);
        run_level(1'b1, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_eq("rstmid_width0", int'(width0), 0);
        expect_eq("rstmid_busy0", int'(busy_v[0]), 0);
        expect_eq("rstmid_valid0", int'(valid_v[0]), 0);
        expect_eq("rstmid_busy2", int'(busy_v[2]), 0);
        run_level(1'b0, 4);

        // Random pulse trains with sporadic arm, abort and reset.
        for (int k = 0; k < 250; k++) begin
            lo     = $urandom_range(1, 6);
            hi     = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 12);
            do_arm = ($urandom_range(0, 1) == 1);
            pulse_in = 1'b0;
            for (int j = 0; j < lo; j++) step_rand(do_arm && (j == 0));
            pulse_in = 1'b1;
            for (int j = 0; j < hi; j++) step_rand($urandom_range(0, 9) == 0);
        end
        run_level(1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Measures the high time of an external pulse in clk cycles and reports it as a count. It is the inverse of the trigger-driven timed-pulse generator: that block turns a trigger into a pulse of fixed length, and this block turns a pulse back into a length.
- Used for loopback checking of generated pulses and for timing user/sensor inputs.
- Single-shot or continuous capture, with glitch rejection and saturation on overflow.

Parameters:
- WIDTH, 24: counter, width output and saturation width in bits.
- MIN_WIDTH, 2: pulses shorter than this many cycles are discarded as glitches. 1 disables rejection.
- CONTINUOUS, 0: 0 returns to IDLE after each capture; 1 re-arms automatically.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pulse_in  input  1  pulse to measure; asynchronous to clk.
- arm  input  1  single-cycle request to start a measurement.
- abort  input  1  cancels any measurement in progress.
- width  output  WIDTH  last captured high time in cycles.
- valid  output  1  one-cycle strobe; width and overflow are updated on that cycle.
- overflow  output  1  the captured pulse saturated the counter.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, both sync flops=0, count=0, width=0, valid=0, overflow=0, busy=0, internal ovf flag=0.
  - rst overrides every other input.
  - rst mid-measurement discards it with no valid.
- Input synchronization:
  - pulse_in passes through a 2-flop synchronizer; s is the second-stage output.
  - All FSM decisions use s only.
- States:
  - IDLE: on arm, go to WAIT_LOW.
  - WAIT_LOW: when s==0, go to WAIT_RISE. This prevents measuring a pulse already in progress when arm arrives.
  - WAIT_RISE: when s==1, set count<=1, clear ovf flag, go to MEASURE.
  - MEASURE, s==1: count<=count+1.
    - If count is already all-ones, count holds all-ones and the ovf flag is set.
  - MEASURE, s==0 and count<MIN_WIDTH: discard the pulse, go to WAIT_RISE, no valid.
  - MEASURE, s==0 and count>=MIN_WIDTH: width<=count, overflow<=ovf flag, valid<=1 for exactly one cycle. Next state is IDLE if CONTINUOUS=0, else WAIT_RISE.
- Arithmetic: unsigned. A pulse sampled high on N consecutive clk edges gives width=N, or all-ones with overflow=1 when N > 2^WIDTH-1.
- Latency: valid rises on the 3rd rising clk edge counting from the first edge at which pulse_in is sampled low (that edge itself is edge 1). The extra 2 edges are the synchronizer.
- Hold behaviour: width and overflow hold their values until the next capture. valid is 0 on every cycle except the capture cycle.
- abort: from any state, next state is IDLE.
  - No valid is generated; width and overflow are left unchanged.
  - abort has priority over arm and over a capture in the same cycle.
- arm: ignored in every state except IDLE. arm and abort in the same cycle leave the block in IDLE.
- busy is decoded from the state register, so it goes high the cycle after the arm edge.

Test Plan:
- Basic capture, MIN_WIDTH=2, CONTINUOUS=0: arm, pulse_in low 5 cycles then high exactly 37 edges then low -> one valid cycle, width=37, overflow=0, busy=0 afterwards. Valid timing matches the latency rule above.
- Pre-high at arm: pulse_in already high when arm is pulsed, stays high 10 edges, falls, then a 20-edge pulse follows -> the first pulse is ignored; width=20.
- Glitch rejection, MIN_WIDTH=2: a 1-edge high pulse then a 6-edge pulse -> no valid for the glitch; width=6, busy stays 1 until the capture.
- Overflow: WIDTH=4, pulse high 40 edges -> width=15, overflow=1, single valid. The next 3-edge pulse (re-armed) -> width=3, overflow=0.
- Continuous mode, CONTINUOUS=1: one arm, then pulses of 4, 9, 2 edges -> three valid strobes with width 4, 9, 2; busy stays 1 throughout.
- Abort and reset:
  - abort raised mid-pulse (count=12) -> IDLE next cycle, no valid, width keeps its previous value.
  - arm during MEASURE -> ignored.
  - rst mid-MEASURE -> all outputs 0 on the next cycle.
